// File: rtl/axis_packet_arbiter_if.sv
// Bundle of per-source AXIS inputs, shared AXIS output and grant vector for axis_packet_arbiter.
// master is the arbiter's view; slave is the surrounding sources/sink.
`ifndef SOURCE_BYTES
`define SOURCE_BYTES 4
`endif

interface axis_packet_arbiter_if #(
  parameter int N_SRC     = 4,
  parameter int DATA_BITS = `SOURCE_BYTES*8,
  parameter int ID_BITS   = $clog2(N_SRC)
);
  logic [N_SRC*DATA_BITS-1:0] axis_s_data_i;
  logic [N_SRC-1:0]           axis_s_valid_i;
  logic [N_SRC-1:0]           axis_s_ready_o;
  logic [N_SRC-1:0]           axis_s_last_i;
  logic [DATA_BITS-1:0]       axis_m_data_o;
  logic                       axis_m_valid_o;
  logic                       axis_m_ready_i;
  logic                       axis_m_last_o;
  logic [ID_BITS-1:0]         axis_m_id_o;
  logic [N_SRC-1:0]           grant_o;

  modport master (
    input  axis_s_data_i, axis_s_valid_i, axis_s_last_i, axis_m_ready_i,
    output axis_s_ready_o, axis_m_data_o, axis_m_valid_o, axis_m_last_o, axis_m_id_o, grant_o
  );

  modport slave (
    output axis_s_data_i, axis_s_valid_i, axis_s_last_i, axis_m_ready_i,
    input  axis_s_ready_o, axis_m_data_o, axis_m_valid_o, axis_m_last_o, axis_m_id_o, grant_o
  );
endinterface

// File: rtl/axis_packet_arbiter.sv
// Packet-granular round-robin arbiter sharing one AXIS datapath among N_SRC sources.
// Grant is held from first beat to the accepted last beat; output is a registered slice tagged with source id.
`ifndef SOURCE_BYTES
`define SOURCE_BYTES 4
`endif

module axis_packet_arbiter #(
  parameter int N_SRC      = 4,
  parameter int DATA_BYTES = `SOURCE_BYTES,
  parameter int DATA_BITS  = DATA_BYTES*8,
  parameter int ID_BITS    = $clog2(N_SRC)
) (
  input logic                clk_i,
  input logic                rstn_i,
  axis_packet_arbiter_if.master bus
);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e               state_q, state_d;
  logic [ID_BITS-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_BITS-1:0]   gnt_q, gnt_d;
  logic [ID_BITS-1:0]   pick, scan;
  logic                 pick_vld;
  logic [N_SRC-1:0]     gnt_oh;
  logic                 busy, slot_free, accept;
  logic                 gnt_valid, gnt_last;
  logic [DATA_BITS-1:0] gnt_data;

  logic                 m_valid_q, m_last_q;
  logic [DATA_BITS-1:0] m_data_q;
  logic [ID_BITS-1:0]   m_id_q;

  // Walk from the far end so the requester closest to rr_ptr wins.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    scan     = '0;
    for (int i = N_SRC-1; i >= 0; i--) begin
      scan = ID_BITS'((int'(rr_ptr_q) + i) % N_SRC);
      if (bus.axis_s_valid_i[scan]) begin
        pick     = scan;
        pick_vld = 1'b1;
      end
    end
  end

  assign busy      = (state_q == BUSY);
  assign gnt_oh    = N_SRC'(1) << gnt_q;
  assign gnt_valid = bus.axis_s_valid_i[gnt_q];
  assign gnt_last  = bus.axis_s_last_i[gnt_q];
  assign gnt_data  = bus.axis_s_data_i[gnt_q*DATA_BITS +: DATA_BITS];
  assign slot_free = !m_valid_q || bus.axis_m_ready_i;
  assign accept    = busy && slot_free && gnt_valid;

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: if (pick_vld) begin
        state_d = BUSY;
        gnt_d   = pick;
      end
      BUSY: if (accept && gnt_last) begin
        state_d  = IDLE;
        rr_ptr_d = (gnt_q == ID_BITS'(N_SRC-1)) ? '0 : gnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Output slice: reload whenever the slot is free, otherwise hold for the sink.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_data_q  <= '0;
      m_id_q    <= '0;
    end else if (slot_free) begin
      m_valid_q <= accept;
      if (accept) begin
        m_data_q <= gnt_data;
        m_last_q <= gnt_last;
        m_id_q   <= gnt_q;
      end
    end
  end

  assign bus.axis_s_ready_o = (busy && slot_free) ? gnt_oh : '0;
  assign bus.grant_o        = busy ? gnt_oh : '0;
  assign bus.axis_m_valid_o = m_valid_q;
  assign bus.axis_m_last_o  = m_last_q;
  assign bus.axis_m_data_o  = m_data_q;
  assign bus.axis_m_id_o    = m_id_q;

endmodule
